vxc_row_writeback: RTL and testbench
====================================

VXC_ROW_WRITEBACK -- requirements
Module: vxc_row_writeback

Interface
REQ-001 SHALL have parameter NI, default 8, complex elements per row vector.
REQ-002 SHALL have parameter element_width, default 64, bits per complex element ({re[63:32], im[31:0]}).
REQ-003 SHALL have parameter DEPTH, default 4, number of buffered row vectors (power of two, >=2).
REQ-004 SHALL have parameter ADDR_W, default 16, destination element-address width.
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  row vector present on in_row this cycle.
REQ-008 SHALL have port in_ready  output  1  buffer can accept a row this cycle.
REQ-009 SHALL have port in_row  input  element_width*NI  row result vector from the vXc add stage.
REQ-010 SHALL have port in_row_addr  input  ADDR_W  destination row index.
REQ-011 SHALL have port out_valid  output  1  out_data/out_addr/out_last valid.
REQ-012 SHALL have port out_ready  input  1  sink accepts the current element.
REQ-013 SHALL have port out_data  output  element_width  current element.
REQ-014 SHALL have port out_addr  output  ADDR_W  destination element address.
REQ-015 SHALL have port out_last  output  1  current element is the final element of its row.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  rows held, including the row being serialized.
REQ-017 SHALL have port overflow  output  1  sticky: a row was offered while in_ready=0.

Function
REQ-018 SHALL push {in_row, in_row_addr} on a cycle with in_valid=1 and in_ready=1; one row per such cycle.
REQ-019 SHALL drive in_ready = (count < DEPTH), registered-state based, not dependent on same-cycle pop.
REQ-020 SHALL drop the row and set overflow=1 when in_valid=1 and in_ready=0; overflow clears only on reset.
REQ-021 SHALL implement a circular buffer with wrapping wr_ptr/rd_ptr; count increments on push, decrements on pop, unchanged on simultaneous push and pop.
REQ-022 SHALL run an output FSM: IDLE (out_valid=0) -> SEND when count>0; SEND holds element index k (0..NI-1) for the head row.
REQ-023 SHALL, in SEND, present element k = head_row[element_width*(NI-k)-1 -: element_width], i.e. MSB slice first.
REQ-024 SHALL drive out_addr = head_row_addr*NI + k, truncated to ADDR_W bits.
REQ-025 SHALL assert out_last when k = NI-1.
REQ-026 SHALL hold out_data, out_addr, out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL increment k on out_valid&out_ready; on transfer with k=NI-1 SHALL pop the head, clear k, and stay in SEND if count after pop >0, else go IDLE.
REQ-028 SHALL sustain one element per cycle with no bubble between consecutive rows when out_ready stays high.
REQ-029 SHALL have first-element latency of 1 cycle: a row pushed into an empty buffer at edge N gives out_valid=1 after edge N.
REQ-030 SHALL not corrupt the head row when a push fills the buffer during a pop.

Reset
REQ-031 SHALL, when reset=1 at a clock edge, set pointers, count, k to 0, FSM to IDLE, out_valid=0, out_last=0, out_data=0, out_addr=0, overflow=0, in_ready=1 after the edge.
REQ-032 SHALL discard all buffered and in-flight rows on reset mid-serialization; no element is emitted in the following cycle.
REQ-033 SHALL ignore in_valid in a cycle where reset=1.

Structure
REQ-034 SHALL take NI, element_width and row-field widths from the shared vXc package used by the add stage.
REQ-035 SHALL place the row storage in one sub-module, vxc_row_fifo (push/pop/full/empty/count); the serializer FSM stays in the top module.

Verification
REQ-036 SHALL test a single row with elements 0x11..0x88, row_addr=3, out_ready=1 -> 8 beats, out_addr 24..31, data 0x11..0x88 in order, out_last on beat 8 only.
REQ-037 SHALL test 4 back-to-back pushes then a 5th, with out_ready=0 -> in_ready=0 after 4, overflow=1, count=4, the 4 stored rows drain intact in order.
REQ-038 SHALL test out_ready toggling 1,0,0,1 -> outputs held during stall, no duplicated or lost element.
REQ-039 SHALL test continuous push of 6 rows with out_ready=1 -> 48 contiguous beats, no bubble, count never exceeds DEPTH.
REQ-040 SHALL test reset asserted at beat 3 of a row -> out_valid=0 next cycle, count=0, overflow=0, next pushed row starts at k=0.
REQ-041 SHALL test row_addr=0x2000 with ADDR_W=16 -> out_addr wraps modulo 2^16 (0x0000..0x0007).

Source files
------------

// File: rtl/vxc_row_writeback_pkg.sv
// Shared vXc datapath constants and the row-writeback serializer state type.
// The add stage imports the same package so row geometry stays in one place.
package vxc_row_writeback_pkg;

  localparam int VXC_NI         = 8;
  localparam int VXC_ELEM_W     = 64;
  localparam int VXC_ROW_ADDR_W = 16;
  localparam int VXC_WB_DEPTH   = 4;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_SEND = 1'b1
  } wb_state_e;

  // Width of one buffered entry: the row payload plus its destination index.
  function automatic int wb_entry_w(input int ni, input int ew, input int aw);
    return ni * ew + aw;
  endfunction

endpackage

// File: rtl/vxc_row_fifo.sv
// Circular buffer of whole row entries; head is read combinationally at rd_ptr.
// Pointers wrap naturally because DEPTH is a power of two.
module vxc_row_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vxc_row_writeback.sv
// Buffers vXc result rows and serializes each into per-element writes,
// MSB element first, addressed at row_addr*NI + k.
module vxc_row_writeback
  import vxc_row_writeback_pkg::*;
#(
  parameter int NI            = VXC_NI,
  parameter int element_width = VXC_ELEM_W,
  parameter int DEPTH         = VXC_WB_DEPTH,
  parameter int ADDR_W        = VXC_ROW_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [element_width*NI-1:0] in_row,
  input  logic [ADDR_W-1:0]           in_row_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [element_width-1:0]    out_data,
  output logic [ADDR_W-1:0]           out_addr,
  output logic                        out_last,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow
);

  localparam int RW = NI * element_width;
  localparam int EW = wb_entry_w(NI, element_width, ADDR_W);
  localparam int KW = (NI > 1) ? $clog2(NI) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e        state_q;
  logic [KW-1:0]    k_q;
  logic             overflow_q;

  logic [EW-1:0]    head;
  logic [RW-1:0]    head_row;
  logic [ADDR_W-1:0] head_addr;
  logic [CW-1:0]    occ;
  logic             full, empty, push, pop, fire, last_k;
  logic [NI-1:0][element_width-1:0] elems;

  assign {head_row, head_addr} = head;

  assign in_ready = !full;
  assign push     = in_valid && !full && !reset;
  assign fire     = out_valid && out_ready;
  assign last_k   = (k_q == KW'(NI - 1));
  assign pop      = fire && last_k;

  vxc_row_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({in_row, in_row_addr}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (occ)
  );

  // elems[k] is the k-th element to leave, taken from the MSB end of the row.
  for (genvar i = 0; i < NI; i++) begin : g_elem
    assign elems[i] = head_row[element_width*(NI-i)-1 -: element_width];
  end

  // Transition decisions fold in this cycle's push/pop so a row landing in an
  // empty buffer is presented right after its push edge, and rows chain without
  // a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WB_IDLE;
      k_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow_q <= 1'b1;
      case (state_q)
        WB_IDLE: begin
          k_q <= '0;
          if (push || !empty) state_q <= WB_SEND;
        end
        WB_SEND: begin
          if (fire) begin
            if (last_k) begin
              k_q <= '0;
              if (!(occ > CW'(1) || push)) state_q <= WB_IDLE;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        default: begin
          state_q <= WB_IDLE;
          k_q     <= '0;
        end
      endcase
    end
  end

  assign out_valid = (state_q == WB_SEND);
  assign out_data  = out_valid ? elems[k_q] : '0;
  assign out_addr  = out_valid ? ADDR_W'(head_addr * ADDR_W'(NI)) + ADDR_W'(k_q) : '0;
  assign out_last  = out_valid && last_k;
  assign count     = occ;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vxc_row_writeback.sv
// Scoreboard bench for vxc_row_writeback: expected beats are queued at push
// acceptance and checked by a negedge monitor as the DUT emits them.
module tb_vxc_row_writeback;

  localparam int NI = 8;
  localparam int EW = 64;
  localparam int DEPTH = 4;
  localparam int AW = 16;
  localparam int RW = NI * EW;

  typedef logic [EW-1:0] elem_arr_t [NI];
  typedef struct packed {
    logic [EW-1:0] d;
    logic [AW-1:0] a;
    logic          l;
  } beat_t;

  logic            clk, reset;
  logic            in_valid, in_ready;
  logic [RW-1:0]   in_row;
  logic [AW-1:0]   in_row_addr;
  logic            out_valid, out_ready, out_last, overflow;
  logic [EW-1:0]   out_data;
  logic [AW-1:0]   out_addr;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t exp_q[$];

  vxc_row_writeback #(.NI(NI), .element_width(EW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_row_addr(in_row_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard consumer: every handshaken beat must match the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      beat_t x;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got d=%h a=%h l=%b, required no beat", out_data, out_addr, out_last);
      end else begin
        x = exp_q.pop_front();
        if ({out_data, out_addr, out_last} !== x) begin
          n_bad++;
          $display("FAIL beat: got d=%h a=%h l=%b, required d=%h a=%h l=%b",
                   out_data, out_addr, out_last, x.d, x.a, x.l);
        end
      end
    end
  end

  function automatic elem_arr_t rand_row();
    elem_arr_t r;
    for (int i = 0; i < NI; i++) r[i] = {$urandom(), $urandom()};
    return r;
  endfunction

  // Starts and ends just after a rising edge; holds in_valid until accepted.
  task automatic send_row(input elem_arr_t e, input logic [AW-1:0] a);
    logic [RW-1:0] row;
    int t;
    bit acc;
    beat_t b;
    int full;
    for (int i = 0; i < NI; i++) row[EW*(NI-i)-1 -: EW] = e[i];
    in_valid = 1'b1; in_row = row; in_row_addr = a;
    t = 0; acc = 0;
    while (!acc && t <= 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc = 1;
      else begin @(posedge clk); #1; t++; end
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        full = int'(a) * NI + k;
        b.d = e[k]; b.a = full[AW-1:0]; b.l = (k == NI - 1);
        exp_q.push_back(b);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(negedge clk); t++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_row = '1; in_row_addr = 16'h55; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d required 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b required 0", overflow); end
    n_cmp++; if ({out_data, out_addr, out_last} !== '0) begin n_bad++;
      $display("FAIL rst_outputs: got d=%h a=%h l=%b required zeros", out_data, out_addr, out_last); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    elem_arr_t e;
    for (int i = 0; i < NI; i++) e[i] = 64'(8'h11 * (i + 1));
    out_ready = 1'b1;
    send_row(e, 16'd3);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: out_valid got %b required 1", out_valid); end
    n_cmp++; if (out_addr !== 16'd24) begin n_bad++; $display("FAIL single_first_addr: got %0d required 24", out_addr); end
    wait_drain(20, "single");
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle: out_valid got %b required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_overflow();
    out_ready = 1'b0;
    for (int r = 0; r < DEPTH; r++) send_row(rand_row(), 16'(10 + r));
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d required 4", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_ovf_early: got %b required 0", overflow); end
    in_valid = 1'b1; in_row = '1; in_row_addr = 16'd99;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_overflow: got %b required 1", overflow); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count_after_drop: got %0d required 4", count); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(80, "full");
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_ovf_sticky: got %b required 1", overflow); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL full_count_drained: got %0d required 0", count); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    elem_arr_t e;
    int c;
    bit stalled;
    logic [EW+AW+1:0] saved;
    for (int i = 0; i < NI; i++) e[i] = {8{8'(8'hA0 + i)}};
    out_ready = 1'b1;
    send_row(e, 16'd7);
    c = 0; stalled = 0; saved = '0;
    while (exp_q.size() != 0 && c < 64) begin
      out_ready = (c % 4 == 1 || c % 4 == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if ({out_valid, out_data, out_addr, out_last} !== saved) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b d=%h a=%h l=%b, required %h",
                   out_valid, out_data, out_addr, out_last, saved);
        end
      end
      stalled = out_valid && !out_ready;
      saved = {out_valid, out_data, out_addr, out_last};
      @(posedge clk); #1; c++;
    end
    out_ready = 1'b1;
    wait_drain(4, "stall");
  endtask

  task automatic test_back_to_back();
    int seen, first, last, cyc, maxc;
    seen = 0; first = -1; last = -1; cyc = 0; maxc = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int r = 0; r < 6; r++) send_row(rand_row(), 16'(100 + r));
      end
      begin
        while (seen < 6 * NI && cyc < 200) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin
            if (first < 0) first = cyc;
            last = cyc; seen++;
          end
          if (int'(count) > maxc) maxc = int'(count);
          cyc++;
        end
      end
    join
    n_cmp++; if (seen != 6 * NI) begin n_bad++; $display("FAIL b2b_beats: got %0d required 48", seen); end
    n_cmp++; if (last - first + 1 != 6 * NI) begin n_bad++; $display("FAIL b2b_bubble: span %0d cycles required 48", last - first + 1); end
    n_cmp++; if (maxc > DEPTH) begin n_bad++; $display("FAIL b2b_count_max: got %0d required <= 4", maxc); end
    wait_drain(10, "b2b");
  endtask

  task automatic test_addr_wrap();
    out_ready = 1'b1;
    send_row(rand_row(), 16'h2000);
    @(negedge clk);
    n_cmp++; if (out_addr !== 16'h0000) begin n_bad++; $display("FAIL wrap_first_addr: got %h required 0000", out_addr); end
    wait_drain(20, "wrap");
  endtask

  task automatic test_reset_mid();
    elem_arr_t e;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL rmid_ovf_before: got %b required 1", overflow); end
    @(posedge clk); #1;
    send_row(rand_row(), 16'd5);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d required 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_overflow: got %b required 0", overflow); end
    @(posedge clk); #1;
    e = rand_row();
    send_row(e, 16'd2);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_addr !== 16'd16 || out_last !== 1'b0 || out_data !== e[0]) begin
      n_bad++;
      $display("FAIL rmid_restart: got v=%b a=%0d l=%b d=%h, required v=1 a=16 l=0 d=%h",
               out_valid, out_addr, out_last, out_data, e[0]);
    end
    wait_drain(20, "rmid");
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_row = '0; in_row_addr = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_full_overflow();
    test_stall();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL leftover: %0d beats never emitted, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
